if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and drives the instruction-memory request/acknowledge handshake.
- Loads the IF/ID pipeline register, which feeds the ID stage (control unit, hazard unit and jump/branch address logic).
- Accepts the redirect target selected by the jump/branch/jr mux chain and a stall from the hazard unit; squashes wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID on flush or bubble (sll $0,$0,0)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  reset, asynchronous, active-low
In_NextPC  input  32  redirect target from the jr mux output; bits [1:0] ignored
Ctrl_Redirect  input  1  taken branch / j / jal / jr resolved in ID this cycle
Ctrl_Stall  input  1  hazard-unit stall; PC and IF/ID hold
Imem_Req  output  1  fetch request to instruction memory
Imem_Addr  output  32  fetch address; equals PC, bits [1:0] always 0
Imem_Ack  input  1  instruction memory returns Imem_Data this cycle
Imem_Data  input  32  fetched instruction word
PC_out  output  32  current PC (debug/trace)
IFID_Instr  output  32  instruction presented to ID
IFID_PC_plus_4  output  32  PC+4 of that instruction; feeds BTA adder and jal writeback
IFID_Valid  output  1  IF/ID holds a real instruction

Behaviour:
- Reset values (async, immediate on rst_n low):
  - PC = RESET_PC; state = IDLE; Imem_Req = 0.
  - IFID_Instr = NOP_INSTR; IFID_PC_plus_4 = 0; IFID_Valid = 0; internal buffer cleared.
- States:
  - IDLE: one cycle after reset release, then FETCH.
  - FETCH: Imem_Req = 1.
  - HOLD: word captured during a stall.
  - DROP: wrong-path request outstanding.
- Handshake:
  - Once Imem_Req rises, Imem_Addr is held stable until the cycle Imem_Ack = 1.
  - Imem_Req drops only in HOLD and IDLE, or is re-asserted the next cycle with a new address.
  - Imem_Ack with Imem_Req = 0 is ignored.
- Priority: Ctrl_Redirect > Ctrl_Stall > normal flow.
- FETCH:
  - Ack, no stall, no redirect: IFID_Instr <= Imem_Data; IFID_PC_plus_4 <= PC+4; IFID_Valid <= 1; PC <= PC+4; stay in FETCH. Throughput is 1 instr/cycle with zero-wait memory.
  - No ack, no stall: IFID_Instr <= NOP_INSTR, IFID_Valid <= 0 (bubble).
  - Ack during stall: word and PC+4 captured into buffer; PC and IF/ID hold; go to HOLD.
  - No ack during stall: IF/ID and PC hold.
- HOLD:
  - Imem_Req = 0; IF/ID holds while Ctrl_Stall = 1.
  - First cycle with stall low: buffer moves to IF/ID (Valid = 1); PC <= PC+4; go to FETCH.
- Redirect, any state:
  - PC <= {In_NextPC[31:2], 2'b00}; IFID_Instr <= NOP_INSTR; IFID_Valid <= 0; buffer discarded.
  - In FETCH with no Ack that cycle, go to DROP; otherwise go to FETCH.
- DROP:
  - Imem_Req stays 1 at the old address until Ack; returned data is discarded.
  - Next cycle: FETCH at the new PC. IF/ID carries bubbles meanwhile.
  - A further redirect in DROP updates PC only; still waits for the outstanding Ack.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Reset mid-request: state is abandoned and a late Ack is ignored. Memory must tolerate the dropped request.
- PC_out = PC register. Imem_Addr = PC in FETCH; in DROP it is the latched old address.

Test Plan:
- Reset and stream: release rst_n, zero-wait memory returning Addr^32'hA5A5_0000 → Imem_Req rises in 2nd cycle; IFID_Instr sequence for addrs 0,4,8 on consecutive cycles; IFID_PC_plus_4 = 4,8,12; Valid = 1.
- Wait states: Ack 2 cycles after Req at PC = 0x10 → Imem_Addr stable at 0x10 for both cycles; IFID_Valid = 0 bubbles; instruction appears with IFID_PC_plus_4 = 0x14.
- Stall: Ctrl_Stall high 3 cycles while Ack arrives for 0x20 → IF/ID unchanged, Req low in HOLD; on release IFID_PC_plus_4 = 0x24, next Imem_Addr = 0x24.
- Redirect during outstanding request: Req at 0x30 pending, Ctrl_Redirect with In_NextPC = 0x103 → IFID_Valid = 0; Req stays at 0x30 until Ack; that data never reaches IF/ID; next Imem_Addr = 0x100.
- Redirect + Stall same cycle at PC = 0x40, In_NextPC = 0x200 → redirect wins: PC = 0x200, IF/ID = NOP_INSTR, Valid = 0.
- Wrap and async reset: PC = 0xFFFF_FFFC accepted → next PC = 0; assert rst_n low mid-wait → all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/imem_if.sv
// imem_if: instruction-memory request/acknowledge handshake between fetch stage and memory.
interface imem_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;
    modport master (output req, addr, input ack, data);
    modport slave  (input req, addr, output ack, data);
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS IF stage owning the PC, the imem handshake and the IF/ID register.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   In_NextPC,
    input  logic          Ctrl_Redirect,
    input  logic          Ctrl_Stall,
    imem_if.master        imem,
    output logic [31:0]   PC_out,
    output logic [31:0]   IFID_Instr,
    output logic [31:0]   IFID_PC_plus_4,
    output logic          IFID_Valid
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;
    state_t      state;
    logic [31:0] pc, addr, hold_instr, hold_pc4, pc4, target;
    logic        ack;
    assign pc4       = pc + 32'd4;
    assign target    = In_NextPC & ~32'h3;
    assign ack       = imem.req & imem.ack;
    assign imem.req  = (state == FETCH) || (state == DROP);
    assign imem.addr = addr;
    assign PC_out    = pc;
    // addr follows pc except in DROP, where it keeps the abandoned request stable until acked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            addr           <= RESET_PC;
            IFID_Instr     <= NOP_INSTR;
            IFID_PC_plus_4 <= '0;
            IFID_Valid     <= 1'b0;
            hold_instr     <= NOP_INSTR;
            hold_pc4       <= '0;
        end else if (Ctrl_Redirect) begin
            pc         <= target;
            IFID_Instr <= NOP_INSTR;
            IFID_Valid <= 1'b0;
            hold_instr <= NOP_INSTR;
            hold_pc4   <= '0;
            if (imem.req && !ack) begin
                state <= DROP;
            end else begin
                state <= FETCH;
                addr  <= target;
            end
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (Ctrl_Stall) begin
                        if (ack) begin
                            hold_instr <= imem.data;
                            hold_pc4   <= pc4;
                            state      <= HOLD;
                        end
                    end else if (ack) begin
                        IFID_Instr     <= imem.data;
                        IFID_PC_plus_4 <= pc4;
                        IFID_Valid     <= 1'b1;
                        pc             <= pc4;
                        addr           <= pc4;
                    end else begin
                        IFID_Instr <= NOP_INSTR;
                        IFID_Valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!Ctrl_Stall) begin
                        IFID_Instr     <= hold_instr;
                        IFID_PC_plus_4 <= hold_pc4;
                        IFID_Valid     <= 1'b1;
                        pc             <= pc4;
                        addr           <= pc4;
                        state          <= FETCH;
                    end
                end
                DROP: begin
                    IFID_Instr <= NOP_INSTR;
                    IFID_Valid <= 1'b0;
                    if (ack) begin
                        state <= FETCH;
                        addr  <= pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed test-plan scenarios plus randomized traffic against a program-order model.
module tb_if_fetch_stage;
    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] next_pc = '0;
    logic        redirect = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] pc_out, instr, pc4;
    logic        valid;
    int          total = 0;
    int          passed = 0;
    imem_if bus();
    if_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .In_NextPC(next_pc), .Ctrl_Redirect(redirect),
        .Ctrl_Stall(stall), .imem(bus), .PC_out(pc_out), .IFID_Instr(instr),
        .IFID_PC_plus_4(pc4), .IFID_Valid(valid)
    );
    always #5 clk = ~clk;
    // memory answers only a live request, with data derived from the address it sees
    task automatic cycle(input bit a);
        bus.ack  = a && bus.req;
        bus.data = bus.addr ^ K;
        @(posedge clk);
        #1;
    endtask
    task automatic expect_ifid(input string n, input logic [31:0] ei, input logic [31:0] ep, input logic ev);
        total++; if ({instr, pc4, valid} !== {ei, ep, ev}) $display("FAIL %s: ifid got %h/%h/%b want %h/%h/%b", n, instr, pc4, valid, ei, ep, ev); else passed++;
    endtask
    task automatic test_reset;
        bus.ack = 1'b0; bus.data = '0;
        #3;
        total++; if ({bus.req, pc_out, instr, pc4, valid} !== {1'b0, 32'h0, NOP, 32'h0, 1'b0}) $display("FAIL reset: req=%b pc=%h instr=%h pc4=%h v=%b", bus.req, pc_out, instr, pc4, valid); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask
    task automatic test_stream;
        cycle(1);
        total++; if ({bus.req, bus.addr, valid} !== {1'b1, 32'h0, 1'b0}) $display("FAIL stream_req: req=%b addr=%h v=%b want 1/0/0", bus.req, bus.addr, valid); else passed++;
        for (int i = 0; i < 3; i++) begin
            cycle(1);
            expect_ifid("stream", (i * 4) ^ K, (i + 1) * 4, 1'b1);
        end
        cycle(1);
        expect_ifid("stream_c", 32'hC ^ K, 32'h10, 1'b1);
    endtask
    task automatic test_wait_states;
        for (int i = 0; i < 2; i++) begin
            cycle(0);
            total++; if ({bus.req, bus.addr} !== {1'b1, 32'h10}) $display("FAIL wait_addr: req=%b addr=%h want 1/00000010", bus.req, bus.addr); else passed++;
            expect_ifid("wait_bubble", NOP, 32'h10, 1'b0);
        end
        cycle(1);
        expect_ifid("wait_done", 32'h10 ^ K, 32'h14, 1'b1);
    endtask
    task automatic test_stall;
        repeat (3) cycle(1);
        expect_ifid("pre_stall", 32'h1C ^ K, 32'h20, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1);
            expect_ifid("stall_hold", 32'h1C ^ K, 32'h20, 1'b1);
            total++; if ({bus.req, pc_out} !== {1'b0, 32'h20}) $display("FAIL stall_req: req=%b pc=%h want 0/00000020", bus.req, pc_out); else passed++;
        end
        stall = 1'b0;
        cycle(0);
        expect_ifid("stall_release", 32'h20 ^ K, 32'h24, 1'b1);
        total++; if ({bus.req, bus.addr} !== {1'b1, 32'h24}) $display("FAIL stall_next: req=%b addr=%h want 1/00000024", bus.req, bus.addr); else passed++;
    endtask
    task automatic test_redirect_drop;
        repeat (3) cycle(1);
        cycle(0);
        redirect = 1'b1; next_pc = 32'h103;
        cycle(0);
        redirect = 1'b0;
        expect_ifid("drop_flush", NOP, 32'h30, 1'b0);
        total++; if ({bus.req, bus.addr, pc_out} !== {1'b1, 32'h30, 32'h100}) $display("FAIL drop_addr: req=%b addr=%h pc=%h want 1/00000030/00000100", bus.req, bus.addr, pc_out); else passed++;
        cycle(0);
        total++; if ({bus.req, bus.addr} !== {1'b1, 32'h30}) $display("FAIL drop_hold: req=%b addr=%h want 1/00000030", bus.req, bus.addr); else passed++;
        cycle(1);
        expect_ifid("drop_discard", NOP, 32'h30, 1'b0);
        total++; if ({bus.req, bus.addr} !== {1'b1, 32'h100}) $display("FAIL drop_next: req=%b addr=%h want 1/00000100", bus.req, bus.addr); else passed++;
        cycle(1);
        expect_ifid("drop_target", 32'h100 ^ K, 32'h104, 1'b1);
    endtask
    task automatic test_redirect_stall;
        redirect = 1'b1; next_pc = 32'h40;
        cycle(1);
        stall = 1'b1; next_pc = 32'h200;
        cycle(1);
        redirect = 1'b0; stall = 1'b0;
        expect_ifid("redir_stall", NOP, 32'h104, 1'b0);
        total++; if ({pc_out, bus.addr} !== {32'h200, 32'h200}) $display("FAIL redir_stall_pc: pc=%h addr=%h want 00000200", pc_out, bus.addr); else passed++;
    endtask
    task automatic test_wrap;
        redirect = 1'b1; next_pc = 32'hFFFF_FFFF;
        cycle(1);
        redirect = 1'b0;
        cycle(1);
        expect_ifid("wrap", 32'hFFFF_FFFC ^ K, 32'h0, 1'b1);
        total++; if ({pc_out, bus.addr} !== {32'h0, 32'h0}) $display("FAIL wrap_pc: pc=%h addr=%h want 0", pc_out, bus.addr); else passed++;
    endtask
    task automatic test_async_reset;
        cycle(0);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({bus.req, pc_out, instr, pc4, valid} !== {1'b0, 32'h0, NOP, 32'h0, 1'b0}) $display("FAIL async_reset: req=%b pc=%h instr=%h pc4=%h v=%b", bus.req, pc_out, instr, pc4, valid); else passed++;
        bus.ack = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.ack = 1'b1;
        @(posedge clk); #1;
        expect_ifid("late_ack", NOP, 32'h0, 1'b0);
    endtask
    // program-order model: the next instruction delivered must be the one at exp_pc
    task automatic test_random;
        logic [31:0] exp_pc, p_addr, p_instr, p_pc4, tgt;
        logic        p_req, p_ack, p_valid, rd, st;
        exp_pc = 32'h0;
        for (int n = 0; n < 600; n++) begin
            rd  = ($urandom_range(9) == 0);
            st  = ($urandom_range(3) == 0);
            tgt = ($urandom_range(7) == 0) ? 32'hFFFF_FFFD : $urandom;
            redirect = rd; stall = st; next_pc = tgt;
            p_req = bus.req; p_addr = bus.addr; p_instr = instr; p_pc4 = pc4; p_valid = valid;
            cycle($urandom_range(2) != 0);
            p_ack = bus.ack;
            if (p_req && !p_ack) begin
                total++; if ({bus.req, bus.addr} !== {1'b1, p_addr}) $display("FAIL rnd_handshake: req=%b addr=%h want 1/%h", bus.req, bus.addr, p_addr); else passed++;
            end
            if (rd) begin
                exp_pc = tgt & ~32'h3;
                total++; if ({valid, instr, pc_out} !== {1'b0, NOP, exp_pc}) $display("FAIL rnd_redirect: v=%b instr=%h pc=%h want 0/%h/%h", valid, instr, pc_out, NOP, exp_pc); else passed++;
            end else if (st) begin
                total++; if ({instr, pc4, valid} !== {p_instr, p_pc4, p_valid}) $display("FAIL rnd_stall: got %h/%h/%b want %h/%h/%b", instr, pc4, valid, p_instr, p_pc4, p_valid); else passed++;
            end else if (valid) begin
                total++; if ({instr, pc4, pc_out} !== {exp_pc ^ K, exp_pc + 32'd4, exp_pc + 32'd4}) $display("FAIL rnd_deliver: instr=%h pc4=%h pc=%h want %h/%h", instr, pc4, pc_out, exp_pc ^ K, exp_pc + 32'd4); else passed++;
                exp_pc = exp_pc + 32'd4;
            end
        end
        redirect = 1'b0; stall = 1'b0;
    endtask
    initial begin
        test_reset;
        test_stream;
        test_wait_states;
        test_stall;
        test_redirect_drop;
        test_redirect_stall;
        test_wrap;
        test_async_reset;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
